// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
// Signal bundle for mem_port_arbiter: fetch port, data port, exception
// input and the single shared memory port.
//   slave  - the arbiter's view (requests in, responses and memory strobes out)
//   master - the surrounding core/memory view
interface mem_port_arbiter_if;
   // fetch port
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ack;
   logic        i_err;
   // data port
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        d_err;
   // hardware exception
   logic        exc_req;
   logic [31:0] exc_code;
   logic        exc_done;
   // memory side
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic        mem_cause_write;
   logic [31:0] mem_cause_code;
   logic [31:0] mem_rdata;

   modport slave (
      input  i_req, i_addr,
      input  d_req, d_we, d_addr, d_wdata,
      input  exc_req, exc_code,
      input  mem_rdata,
      output i_rdata, i_ack, i_err,
      output d_rdata, d_ack, d_err,
      output exc_done,
      output mem_addr, mem_wdata, mem_read, mem_write,
      output mem_cause_write, mem_cause_code
   );

   modport master (
      output i_req, i_addr,
      output d_req, d_we, d_addr, d_wdata,
      output exc_req, exc_code,
      output mem_rdata,
      input  i_rdata, i_ack, i_err,
      input  d_rdata, d_ack, d_err,
      input  exc_done,
      input  mem_addr, mem_wdata, mem_read, mem_write,
      input  mem_cause_write, mem_cause_code
   );
endinterface

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Shares one single-cycle memory port between a fetch port and a data port.
// Each access runs IDLE -> ACCESS -> RESP (ack two cycles after the request
// is first seen in IDLE). A pending hardware exception takes a one-cycle
// CAUSE slot from IDLE to write the Cause register; it never interrupts an
// access already in flight. Simultaneous requests alternate round-robin.
module mem_port_arbiter #(
   parameter logic [31:0] CAUSE_ADDR = 32'h0000_0800,
   parameter logic [31:0] MEM_TOP    = 32'h0000_07FC
) (
   input  logic             clk,
   input  logic             rst,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2,
      CAUSE  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nx;

   // grant decisions made in IDLE
   logic        grant_i;
   logic        grant_d;

   // latched transaction
   logic        port_d;      // 1 = data port owns the current access
   logic        lat_we;
   logic        lat_err;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   // registered responses
   logic [31:0] i_rdata_q;
   logic [31:0] d_rdata_q;
   logic [31:0] access_rdata;

   // round-robin: 1 = data port was served last, so a tie goes to fetch
   logic        last_d;

   // exception capture
   logic        exc_pending;
   logic [31:0] exc_code_q;

   // one-cycle strobes decoded from the state
   logic        i_ack;
   logic        i_err;
   logic        d_ack;
   logic        d_err;
   logic        exc_done;
   logic        mem_read;
   logic        mem_write;
   logic        mem_cause_write;

   // Misaligned, beyond the array (except the Cause register), or an
   // instruction fetch from the Cause register.
   function automatic logic access_err(input logic [31:0] addr, input logic fetch);
      logic misaligned;
      logic cause_hit;
      logic out_of_range;
      misaligned   = (addr[1:0] != 2'b00);
      cause_hit    = (addr == CAUSE_ADDR);
      out_of_range = (addr > MEM_TOP) && !cause_hit;
      return misaligned || out_of_range || (fetch && cause_hit);
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state, grant arbitration and the per-state strobes.
   always_comb begin
      state_nx        = state;
      grant_i         = 1'b0;
      grant_d         = 1'b0;
      i_ack           = 1'b0;
      i_err           = 1'b0;
      d_ack           = 1'b0;
      d_err           = 1'b0;
      exc_done        = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_cause_write = 1'b0;
      case (state)
         IDLE: begin
            if (exc_pending) begin
               state_nx = CAUSE;
            end else if (bus.i_req && bus.d_req) begin
               grant_i  = last_d;
               grant_d  = !last_d;
               state_nx = ACCESS;
            end else if (bus.i_req) begin
               grant_i  = 1'b1;
               state_nx = ACCESS;
            end else if (bus.d_req) begin
               grant_d  = 1'b1;
               state_nx = ACCESS;
            end
         end
         ACCESS: begin
            mem_read  = !lat_err && !lat_we;
            mem_write = !lat_err &&  lat_we;
            state_nx  = RESP;
         end
         RESP: begin
            i_ack    = !port_d;
            i_err    = !port_d && lat_err;
            d_ack    =  port_d;
            d_err    =  port_d && lat_err;
            state_nx = IDLE;
         end
         CAUSE: begin
            mem_cause_write = 1'b1;
            exc_done        = 1'b1;
            state_nx        = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Transaction latch: captured on grant and held until the next grant, so
   // mem_addr/mem_wdata keep their last value outside ACCESS.
   always_ff @(posedge clk) begin
      if (rst) begin
         port_d  <= 1'b0;
         lat_we  <= 1'b0;
         lat_err <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (grant_d) begin
         port_d  <= 1'b1;
         lat_we  <= bus.d_we;
         lat_err <= access_err(bus.d_addr, 1'b0);
         addr_q  <= bus.d_addr;
         wdata_q <= bus.d_wdata;
      end else if (grant_i) begin
         port_d  <= 1'b0;
         lat_we  <= 1'b0;
         lat_err <= access_err(bus.i_addr, 1'b1);
         addr_q  <= bus.i_addr;
      end
   end

   // Writes and errored accesses respond with zero data.
   assign access_rdata = (lat_err || lat_we) ? '0 : bus.mem_rdata;

   // Response data registered at the end of ACCESS for the owning port.
   always_ff @(posedge clk) begin
      if (rst) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else if (state == ACCESS) begin
         if (port_d) begin
            d_rdata_q <= access_rdata;
         end else begin
            i_rdata_q <= access_rdata;
         end
      end
   end

   // Round-robin pointer: remembers the port just served; CAUSE slots leave it.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_d <= 1'b1;
      end else if (state == RESP) begin
         last_d <= port_d;
      end
   end

   // Exception capture. A new pulse takes priority over the clear in CAUSE,
   // so a pulse landing in the CAUSE cycle re-arms another slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         exc_pending <= 1'b0;
         exc_code_q  <= '0;
      end else if (bus.exc_req) begin
         exc_pending <= 1'b1;
         exc_code_q  <= bus.exc_code;
      end else if (state == CAUSE) begin
         exc_pending <= 1'b0;
      end
   end

   assign bus.i_rdata         = i_rdata_q;
   assign bus.i_ack           = i_ack;
   assign bus.i_err           = i_err;
   assign bus.d_rdata         = d_rdata_q;
   assign bus.d_ack           = d_ack;
   assign bus.d_err           = d_err;
   assign bus.exc_done        = exc_done;
   assign bus.mem_addr        = addr_q;
   assign bus.mem_wdata       = wdata_q;
   assign bus.mem_read        = mem_read;
   assign bus.mem_write       = mem_write;
   assign bus.mem_cause_write = mem_cause_write;
   assign bus.mem_cause_code  = exc_code_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: a behavioural memory with Cause register, a
// table of single transactions, hand-written multi-cycle sequences
// (round-robin, exceptions, reset mid-access) and a randomized phase checked
// against a transaction-level model (shadow memory + last-served port).
module tb_mem_port_arbiter;

   localparam logic [31:0] CAUSE_ADDR = 32'h0000_0800;
   localparam logic [31:0] MEM_TOP    = 32'h0000_07FC;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(
      .CAUSE_ADDR (CAUSE_ADDR),
      .MEM_TOP    (MEM_TOP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural memory ----------------
   logic [31:0] mem [0:511];
   logic [31:0] cause_reg;
   bit          do_init = 1'b0;

   function automatic logic [31:0] init_word(input int unsigned k);
      return 32'hA5A5_0000 ^ (k * 32'h0001_0203);
   endfunction

   always @(posedge clk) begin
      if (do_init) begin
         for (int k = 0; k < 512; k++) mem[k] <= init_word(k);
         cause_reg <= '0;
      end else begin
         if (bus.mem_write) begin
            if (bus.mem_addr == CAUSE_ADDR) cause_reg <= bus.mem_wdata;
            else if (bus.mem_addr <= MEM_TOP) mem[bus.mem_addr[10:2]] <= bus.mem_wdata;
         end
         if (bus.mem_cause_write) cause_reg <= bus.mem_cause_code;
      end
   end

   always_comb begin
      if (bus.mem_addr == CAUSE_ADDR)   bus.mem_rdata = cause_reg;
      else if (bus.mem_addr <= MEM_TOP) bus.mem_rdata = mem[bus.mem_addr[10:2]];
      else                              bus.mem_rdata = 32'hDEAD_0BAD;
   end

   // strobe counters
   int rd_cnt = 0;
   int wr_cnt = 0;
   always @(negedge clk) begin
      if (bus.mem_read)  rd_cnt++;
      if (bus.mem_write) wr_cnt++;
   end

   // ---------------- helpers ----------------
   typedef struct packed {
      logic        got;
      logic [31:0] cyc;
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   // Drives one or both requests from an IDLE negedge and holds each until
   // its ack; returns the cycle (negedges after issue) of each ack.
   task automatic run_pair(input bit ui, input logic [31:0] ia,
                           input bit ud, input bit dwe, input logic [31:0] da,
                           input logic [31:0] dwd,
                           output resp_t ri, output resp_t rd);
      ri = '0;
      rd = '0;
      bus.i_req   = ui;
      bus.i_addr  = ia;
      bus.d_req   = ud;
      bus.d_we    = dwe;
      bus.d_addr  = da;
      bus.d_wdata = dwd;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (bus.i_ack && !ri.got) begin
            ri.got = 1'b1; ri.cyc = 32'(c); ri.rdata = bus.i_rdata; ri.err = bus.i_err;
            bus.i_req = 1'b0;
         end
         if (bus.d_ack && !rd.got) begin
            rd.got = 1'b1; rd.cyc = 32'(c); rd.rdata = bus.d_rdata; rd.err = bus.d_err;
            bus.d_req = 1'b0;
         end
         if ((ri.got || !ui) && (rd.got || !ud)) break;
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check1 ({tag, "_i_ack"},     bus.i_ack,           1'b0);
      check1 ({tag, "_i_err"},     bus.i_err,           1'b0);
      check1 ({tag, "_d_ack"},     bus.d_ack,           1'b0);
      check1 ({tag, "_d_err"},     bus.d_err,           1'b0);
      check1 ({tag, "_exc_done"},  bus.exc_done,        1'b0);
      check1 ({tag, "_mem_read"},  bus.mem_read,        1'b0);
      check1 ({tag, "_mem_write"}, bus.mem_write,       1'b0);
      check1 ({tag, "_cause_wr"},  bus.mem_cause_write, 1'b0);
      check32({tag, "_i_rdata"},   bus.i_rdata,         32'h0);
      check32({tag, "_d_rdata"},   bus.d_rdata,         32'h0);
      check32({tag, "_mem_addr"},  bus.mem_addr,        32'h0);
      check32({tag, "_mem_wdata"}, bus.mem_wdata,       32'h0);
      check32({tag, "_cause_cd"},  bus.mem_cause_code,  32'h0);
   endtask

   // ---------------- reference model ----------------
   logic [31:0] shadow [logic [31:0]];
   bit          m_last_d;

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (shadow.exists(a)) return shadow[a];
      if (a == CAUSE_ADDR)  return 32'h0;
      return init_word(32'(a >> 2));
   endfunction

   task automatic model_access(input bit fetch, input bit we, input logic [31:0] a,
                               input logic [31:0] wd,
                               output logic err, output logic [31:0] rd);
      bit bad_align, beyond, fetch_cause;
      bad_align   = (a % 4) != 0;
      beyond      = (a > MEM_TOP) && (a != CAUSE_ADDR);
      fetch_cause = fetch && (a == CAUSE_ADDR);
      err = bad_align || beyond || fetch_cause;
      rd  = 32'h0;
      if (!err) begin
         if (!fetch && we) shadow[a] = wd;
         else              rd = model_read(a);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r <= 5)      return 32'($urandom_range(0, 15)) << 2;
      else if (r == 6) return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 7) return CAUSE_ADDR + 32'd4 + (32'($urandom_range(0, 63)) << 2);
      else if (r == 8) return CAUSE_ADDR;
      else             return MEM_TOP;
   endfunction

   // ---------------- directed vectors ----------------
   typedef struct packed {
      logic        fetch;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   vec_t vt [14];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time (n_bad=%0d)", n_bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      resp_t ri, rd;
      int    rd0, wr0;
      logic [31:0] q_cyc [$];
      logic        q_port [$];

      //           fetch we    addr           wdata          err   rdata
      vt[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0};
      vt[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h1234_5678};
      vt[2]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_BABE, 1'b0, 32'h0};
      vt[3]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hCAFE_BABE};
      vt[4]  = '{1'b0, 1'b0, 32'h0000_0022, 32'h0,         1'b1, 32'h0};
      vt[5]  = '{1'b1, 1'b0, 32'h0000_0804, 32'h0,         1'b1, 32'h0};
      vt[6]  = '{1'b1, 1'b0, 32'h0000_0800, 32'h0,         1'b1, 32'h0};
      vt[7]  = '{1'b0, 1'b1, 32'h0000_0800, 32'h0000_0055, 1'b0, 32'h0};
      vt[8]  = '{1'b0, 1'b0, 32'h0000_0800, 32'h0,         1'b0, 32'h0000_0055};
      vt[9]  = '{1'b0, 1'b1, 32'h0000_07FC, 32'h0F0F_0F0F, 1'b0, 32'h0};
      vt[10] = '{1'b1, 1'b0, 32'h0000_07FC, 32'h0,         1'b0, 32'h0F0F_0F0F};
      vt[11] = '{1'b0, 1'b0, 32'h0000_0804, 32'h0,         1'b1, 32'h0};
      vt[12] = '{1'b0, 1'b1, 32'h0000_0042, 32'h1111_2222, 1'b1, 32'h0};
      vt[13] = '{1'b0, 1'b0, 32'h0000_0024, 32'h0,         1'b0, 32'hA5A5_0000 ^ (32'd9 * 32'h0001_0203)};

      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.exc_req = 1'b0; bus.exc_code = '0;

      // ---- reset state ----
      rst = 1'b1;
      do_init = 1'b1;
      repeat (2) @(negedge clk);
      do_init = 1'b0;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // ---- table-driven single transactions ----
      for (int v = 0; v < 14; v++) begin
         rd0 = rd_cnt;
         wr0 = wr_cnt;
         run_pair(vt[v].fetch, vt[v].addr, !vt[v].fetch, vt[v].we, vt[v].addr, vt[v].wdata, ri, rd);
         if (vt[v].fetch) begin
            check1 ($sformatf("vec%0d_ack", v),   ri.got,   1'b1);
            check32($sformatf("vec%0d_lat", v),   ri.cyc,   32'd2);
            check32($sformatf("vec%0d_rdata", v), ri.rdata, vt[v].rdata);
            check1 ($sformatf("vec%0d_err", v),   ri.err,   vt[v].err);
            check1 ($sformatf("vec%0d_other", v), rd.got,   1'b0);
         end else begin
            check1 ($sformatf("vec%0d_ack", v),   rd.got,   1'b1);
            check32($sformatf("vec%0d_lat", v),   rd.cyc,   32'd2);
            check32($sformatf("vec%0d_rdata", v), rd.rdata, vt[v].rdata);
            check1 ($sformatf("vec%0d_err", v),   rd.err,   vt[v].err);
            check1 ($sformatf("vec%0d_other", v), ri.got,   1'b0);
         end
         check32($sformatf("vec%0d_nread", v),  32'(rd_cnt - rd0),
                 32'(!vt[v].err && !vt[v].we));
         check32($sformatf("vec%0d_nwrite", v), 32'(wr_cnt - wr0),
                 32'(!vt[v].err && vt[v].we));
      end

      // ---- round-robin with both requests held after reset ----
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      bus.i_req = 1'b1; bus.i_addr = 32'h10;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (bus.i_ack) begin q_cyc.push_back(32'(c)); q_port.push_back(1'b0); end
         if (bus.d_ack) begin q_cyc.push_back(32'(c)); q_port.push_back(1'b1); end
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      repeat (2) @(negedge clk);
      check32("rr_ack_count", 32'(q_cyc.size()), 32'd5);
      while (q_cyc.size() < 4) begin q_cyc.push_back(32'hFFFF); q_port.push_back(1'bx); end
      for (int k = 0; k < 4; k++) begin
         check1 ($sformatf("rr_port%0d", k), q_port[k], (k % 2) == 1);
         check32($sformatf("rr_cyc%0d", k),  q_cyc[k],  32'(2 + 3 * k));
      end

      // ---- exception during a data access, then a waiting fetch ----
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         check1($sformatf("exc1_d_ack_c%0d", c),    bus.d_ack,           c == 2);
         check1($sformatf("exc1_i_ack_c%0d", c),    bus.i_ack,           c == 7);
         check1($sformatf("exc1_done_c%0d", c),     bus.exc_done,        c == 4);
         check1($sformatf("exc1_cause_wr_c%0d", c), bus.mem_cause_write, c == 4);
         if (c == 2) check32("exc1_d_rdata", bus.d_rdata, 32'hCAFE_BABE);
         if (c == 4) check32("exc1_cause_code", bus.mem_cause_code, 32'h0000_000A);
         if (c == 7) check32("exc1_i_rdata", bus.i_rdata, 32'hCAFE_BABE);
         if (c == 1) begin bus.exc_req = 1'b1; bus.exc_code = 32'h0000_000A; end
         if (c == 2) begin
            bus.exc_req = 1'b0;
            bus.d_req = 1'b0;
            bus.i_req = 1'b1; bus.i_addr = 32'h20;
         end
         if (c == 7) bus.i_req = 1'b0;
      end
      run_pair(1'b0, 32'h0, 1'b1, 1'b0, CAUSE_ADDR, 32'h0, ri, rd);
      check32("exc1_cause_read", rd.rdata, 32'h0000_000A);
      check1 ("exc1_cause_read_err", rd.err, 1'b0);

      // ---- latest code wins, and a pulse in the CAUSE cycle re-arms ----
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h24;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         check1($sformatf("exc2_d_ack_c%0d", c), bus.d_ack,    c == 2);
         check1($sformatf("exc2_done_c%0d", c),  bus.exc_done, (c == 4) || (c == 6));
         if (c == 4) check32("exc2_code_first",  bus.mem_cause_code, 32'h0000_0007);
         if (c == 6) check32("exc2_code_rearm",  bus.mem_cause_code, 32'h0000_000B);
         case (c)
            1: begin bus.exc_req = 1'b1; bus.exc_code = 32'h3; end
            2: begin bus.exc_code = 32'h7; bus.d_req = 1'b0; end
            3: bus.exc_req = 1'b0;
            4: begin bus.exc_req = 1'b1; bus.exc_code = 32'hB; end
            5: bus.exc_req = 1'b0;
            default: ;
         endcase
      end
      run_pair(1'b0, 32'h0, 1'b1, 1'b0, CAUSE_ADDR, 32'h0, ri, rd);
      check32("exc2_cause_read", rd.rdata, 32'h0000_000B);

      // ---- reset in the middle of a write ----
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check1 ("rst_mid_write_strobe", bus.mem_write, 1'b1);
      check32("rst_mid_write_addr",   bus.mem_addr,  32'h40);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst_mid");
      rst = 1'b0;
      bus.d_req = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check1($sformatf("rst_mid_no_ack_c%0d", c), bus.d_ack | bus.i_ack, 1'b0);
      end
      run_pair(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, ri, rd);
      check1 ("rst_reissue_ack", rd.got, 1'b1);
      check32("rst_reissue_lat", rd.cyc, 32'd2);

      // ---- randomized traffic against the transaction model ----
      rst = 1'b1;
      do_init = 1'b1;
      repeat (2) @(negedge clk);
      do_init = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      shadow.delete();
      m_last_d = 1'b1;
      for (int it = 0; it < 80; it++) begin
         bit          ui, ud, dwe, first_d;
         logic [31:0] ia, da, dwd, e_i_rd, e_d_rd;
         logic        e_i_err, e_d_err;
         logic [31:0] e_i_cyc, e_d_cyc;
         ui  = 1'($urandom_range(0, 1));
         ud  = 1'($urandom_range(0, 1));
         if (!ui && !ud) ud = 1'b1;
         ia  = rand_addr();
         da  = rand_addr();
         dwe = 1'($urandom_range(0, 1));
         dwd = $urandom;
         first_d = (ui && ud) ? !m_last_d : ud;
         e_i_err = 1'b0; e_i_rd = '0; e_d_err = 1'b0; e_d_rd = '0;
         if (first_d) begin
            model_access(1'b0, dwe, da, dwd, e_d_err, e_d_rd);
            if (ui) model_access(1'b1, 1'b0, ia, 32'h0, e_i_err, e_i_rd);
         end else begin
            model_access(1'b1, 1'b0, ia, 32'h0, e_i_err, e_i_rd);
            if (ud) model_access(1'b0, dwe, da, dwd, e_d_err, e_d_rd);
         end
         e_i_cyc = (ui && ud && first_d)  ? 32'd5 : 32'd2;
         e_d_cyc = (ui && ud && !first_d) ? 32'd5 : 32'd2;
         m_last_d = (ui && ud) ? !first_d : ud;

         run_pair(ui, ia, ud, dwe, da, dwd, ri, rd);
         check1($sformatf("rnd%0d_i_got", it), ri.got, ui);
         check1($sformatf("rnd%0d_d_got", it), rd.got, ud);
         if (ui) begin
            check32($sformatf("rnd%0d_i_cyc", it),   ri.cyc,   e_i_cyc);
            check32($sformatf("rnd%0d_i_rdata", it), ri.rdata, e_i_rd);
            check1 ($sformatf("rnd%0d_i_err", it),   ri.err,   e_i_err);
         end
         if (ud) begin
            check32($sformatf("rnd%0d_d_cyc", it),   rd.cyc,   e_d_cyc);
            check32($sformatf("rnd%0d_d_rdata", it), rd.rdata, e_d_rd);
            check1 ($sformatf("rnd%0d_d_err", it),   rd.err,   e_d_err);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
